// File: rtl/seg_pkg.sv
// Shared constants, state encoding and arithmetic helper for the segment classifier.
package seg_pkg;

    localparam int NUM_SEG  = 6;
    localparam int NUM_QUAD = 4;

    localparam logic [9:0] SEG_X0 [NUM_SEG] = '{10'd50, 10'd140, 10'd230, 10'd335, 10'd425, 10'd515};
    localparam logic [9:0] WIN_L     = 10'd37;
    localparam logic [9:0] WIN_R     = 10'd37;
    localparam logic [9:0] ROW_TOP   = 10'd150;
    localparam logic [9:0] ROW_MID   = 10'd225;
    localparam logic [9:0] ROW_BOT   = 10'd300;
    localparam logic [9:0] TRIG_LINE = 10'd301;

    localparam logic [15:0] TH_DEFAULT = 16'd20000;

    typedef enum logic {
        ST_ACCUM    = 1'b0,
        ST_CLASSIFY = 1'b1
    } state_t;

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [3:0] red);
        logic [16:0] sum;
        sum = {1'b0, acc} + {13'd0, red};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/seg_window_decode.sv
// Maps a pixel position to its segment/quadrant window; in_win low outside all 24 windows.
module seg_window_decode
    import seg_pkg::*;
(
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    output logic       in_win,
    output logic [2:0] seg_idx,
    output logic [1:0] quad
);

    logic row_up;
    logic row_lo;
    logic col_hit;

    assign row_up = (vcnt > ROW_TOP) && (vcnt <= ROW_MID);
    assign row_lo = (vcnt > ROW_MID) && (vcnt <= ROW_BOT);

    always_comb begin
        col_hit = 1'b0;
        seg_idx = 3'd0;
        quad    = 2'd0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if ((hcnt > SEG_X0[s]) && (hcnt <= SEG_X0[s] + WIN_L)) begin
                col_hit = 1'b1;
                seg_idx = 3'(s);
                quad[0] = 1'b0;
            end else if ((hcnt > SEG_X0[s] + WIN_L) && (hcnt <= SEG_X0[s] + WIN_L + WIN_R)) begin
                col_hit = 1'b1;
                seg_idx = 3'(s);
                quad[0] = 1'b1;
            end
        end
        quad[1] = row_lo;
    end

    assign in_win = col_hit && (row_up || row_lo);

endmodule

// File: rtl/segment_classify.sv
// Accumulates red intensity per segment quadrant over a frame, then thresholds
// one segment per cycle into a 24-bit lit mask.
//
//   state       | meaning
//   ST_ACCUM    | summing windowed red into the 24 quadrant accumulators
//   ST_CLASSIFY | evaluating segment idx_q (0..5), one per cycle
module segment_classify
    import seg_pkg::*;
#(
    parameter logic [15:0] TH_Q0 = TH_DEFAULT,
    parameter logic [15:0] TH_Q1 = TH_DEFAULT,
    parameter logic [15:0] TH_Q2 = TH_DEFAULT,
    parameter logic [15:0] TH_Q3 = TH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic [11:0] pixel_in,
    output logic [23:0] seg_pattern,
    output logic        result_valid,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] work_q, work_d;
    logic [23:0] pat_q, pat_d;
    logic        valid_q, valid_d;
    logic [15:0] acc_q [NUM_SEG*NUM_QUAD];
    logic [15:0] acc_d [NUM_SEG*NUM_QUAD];

    logic       in_win;
    logic [2:0] seg_idx;
    logic [1:0] quad;
    logic       frame_start;
    logic       end_trig;
    logic [3:0] nib;
    logic       unused_pix;

    seg_window_decode u_decode (
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .in_win  (in_win),
        .seg_idx (seg_idx),
        .quad    (quad)
    );

    assign frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
    assign end_trig    = (hcnt == 10'd0) && (vcnt == TRIG_LINE);
    assign unused_pix  = ^pixel_in[7:0];

    assign nib[0] = acc_q[{idx_q, 2'd0}] > TH_Q0;
    assign nib[1] = acc_q[{idx_q, 2'd1}] > TH_Q1;
    assign nib[2] = acc_q[{idx_q, 2'd2}] > TH_Q2;
    assign nib[3] = acc_q[{idx_q, 2'd3}] > TH_Q3;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        pat_d   = pat_q;
        valid_d = 1'b0;
        acc_d   = acc_q;

        // Frame start wins in either state; in CLASSIFY it aborts without a result.
        if (frame_start) begin
            for (int i = 0; i < NUM_SEG*NUM_QUAD; i++) acc_d[i] = '0;
            state_d = ST_ACCUM;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (end_trig) begin
                        state_d = ST_CLASSIFY;
                        idx_d   = 3'd0;
                    end else if (pix_valid && in_win) begin
                        acc_d[{seg_idx, quad}] = sat_add(acc_q[{seg_idx, quad}], pixel_in[11:8]);
                    end
                end
                ST_CLASSIFY: begin
                    work_d[{idx_q, 2'b00} +: 4] = nib;
                    if (idx_q == 3'(NUM_SEG - 1)) begin
                        pat_d   = work_d;
                        valid_d = 1'b1;
                        state_d = ST_ACCUM;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            idx_q   <= 3'd0;
            work_q  <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_SEG*NUM_QUAD; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            pat_q   <= pat_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
        end
    end

    assign seg_pattern  = pat_q;
    assign result_valid = valid_q;
    assign busy         = (state_q == ST_CLASSIFY);

endmodule

// File: tb/tb_segment_classify.sv
// Scoreboard bench for segment_classify: expected masks queued at the end trigger, checked on result_valid.
module tb_segment_classify;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [9:0]  hcnt = 10'd700;
    logic [9:0]  vcnt = 10'd400;
    logic [11:0] pixel_in = 12'h000;
    logic [23:0] seg_pattern;
    logic        result_valid;
    logic        busy;

    segment_classify dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .pixel_in     (pixel_in),
        .seg_pattern  (seg_pattern),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [23:0] pat;
        int unsigned at;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int x0 [6] = '{50, 140, 230, 335, 425, 515};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {31'd0, result_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("seg_pattern", {8'h0, seg_pattern}, {8'h0, mon_e.pat});
                chk("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic px(input logic v, input logic [9:0] h, input logic [9:0] vc, input logic [11:0] p);
        pix_valid = v;
        hcnt      = h;
        vcnt      = vc;
        pixel_in  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 10'd700, 10'd400, 12'h000);
    endtask

    task automatic frame_start();
        px(1'b0, 10'd0, 10'd0, 12'h000);
    endtask

    task automatic trig(input logic [23:0] pat);
        exp_t e;
        e.pat = pat;
        e.at  = cyc + 7;
        sb_q.push_back(e);
        px(1'b1, 10'd0, 10'd301, 12'h000);
    endtask

    task automatic trig_raw();
        px(1'b1, 10'd0, 10'd301, 12'h000);
    endtask

    task automatic wait_result();
        idle(10);
        chk("pulse_seen", sb_q.size(), 0);
    endtask

    // Drives red pixels into quadrant q of segment s until exactly 'total' has been added.
    task automatic fill(input int s, input int q, input int total);
        int rem;
        int r;
        int i;
        int h0;
        int v0;
        rem = total;
        i   = 0;
        h0  = x0[s] + 1 + (((q % 2) == 1) ? 37 : 0);
        v0  = (q >= 2) ? 226 : 151;
        while (rem > 0) begin
            r = (rem >= 15) ? 15 : rem;
            px(1'b1, 10'(h0 + i % 37), 10'(v0 + (i / 37) % 75), {r[3:0], 8'hA5});
            rem -= r;
            i++;
        end
    endtask

    initial begin
        idle(3);
        chk("rst_pattern", {8'h0, seg_pattern}, 32'h0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Full-red frame, with busy window checked around the trigger
        frame_start();
        for (int s = 0; s < 6; s++)
            for (int v = 151; v <= 300; v++)
                for (int h = x0[s] + 1; h <= x0[s] + 74; h++)
                    px(1'b1, 10'(h), 10'(v), 12'hF00);
        trig(24'hFFFFFF);
        chk("busy_n1", {31'd0, busy}, 32'd1);
        idle(5);
        chk("busy_n6", {31'd0, busy}, 32'd1);
        idle(1);
        chk("busy_n7", {31'd0, busy}, 32'd0);
        chk("valid_n7", {31'd0, result_valid}, 32'd1);
        wait_result();

        // Only segment 2 Q1 red; green/blue-only pixels elsewhere must not count
        frame_start();
        for (int v = 151; v <= 225; v++)
            for (int h = 268; h <= 304; h++)
                px(1'b1, 10'(h), 10'(v), 12'hF00);
        for (int h = 51; h <= 124; h++) px(1'b1, 10'(h), 10'd200, 12'h0FF);
        trig(24'h000200);
        wait_result();

        // Threshold boundary, dropped pixels and ignored retrigger during CLASSIFY, saturation
        frame_start();
        fill(0, 0, 19995);
        trig(24'h000000);
        px(1'b1, 10'd51, 10'd151, 12'hF00);
        px(1'b1, 10'd0, 10'd301, 12'hF00);
        for (int k = 0; k < 4; k++) px(1'b1, 10'(52 + k), 10'd151, 12'hF00);
        wait_result();
        px(1'b1, 10'd60, 10'd160, 12'h500);
        trig(24'h000000);
        wait_result();
        px(1'b1, 10'd61, 10'd160, 12'h100);
        trig(24'h000001);
        wait_result();
        fill(1, 3, 65550);
        trig(24'h000081);
        wait_result();
        idle(20);
        chk("held_pattern", {8'h0, seg_pattern}, 32'h000081);

        // Window edges: Q0/Q2 land on 20001, Q1/Q3 on 20000 only if edges decode exactly
        frame_start();
        fill(0, 0, 19971);
        fill(0, 2, 19971);
        fill(0, 1, 19940);
        fill(0, 3, 19940);
        foreach (x0[i]) begin end
        begin
            int eh [5] = '{50, 87, 88, 124, 125};
            int ev [6] = '{150, 151, 225, 226, 300, 301};
            foreach (eh[a])
                foreach (ev[b])
                    px(1'b1, 10'(eh[a]), 10'(ev[b]), 12'hF00);
        end
        trig(24'h000005);
        wait_result();

        // Reset at N+3 of CLASSIFY: no pulse, mask cleared, accumulators cleared
        frame_start();
        fill(3, 0, 30000);
        trig_raw();
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_pattern", {8'h0, seg_pattern}, 32'h0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        idle(10);
        fill(4, 3, 20001);
        trig(24'h080000);
        wait_result();

        // Frame start at N+2 aborts: no pulse, mask held, accumulators zero
        fill(5, 2, 25000);
        trig_raw();
        idle(1);
        frame_start();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_held", {8'h0, seg_pattern}, 32'h080000);
        idle(10);
        chk("abort_held_late", {8'h0, seg_pattern}, 32'h080000);
        trig(24'h000000);
        wait_result();

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_classify.md
SEGMENT_CLASSIFY -- requirements
Module: segment_classify

Interface
REQ-001 SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-002 SHALL have parameter TH_Q0..TH_Q3, default 16'd20000 each, per-quadrant "lit" threshold (Q0 UL, Q1 UR, Q2 LL, Q3 LR).
REQ-003 SHALL have port clk, input, 1, pixel clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pix_valid, input, 1, pixel_in/hcnt/vcnt valid this cycle.
REQ-006 SHALL have port hcnt, input, 10, horizontal pixel position.
REQ-007 SHALL have port vcnt, input, 10, vertical line position.
REQ-008 SHALL have port pixel_in, input, 12, RGB444 pixel with red in [11:8].
REQ-009 SHALL have port seg_pattern, output, 24, 4-bit lit mask per segment; segment s in bits [4s+3:4s], bit q = quadrant q.
REQ-010 SHALL have port result_valid, output, 1, one-cycle pulse when seg_pattern updates.
REQ-011 SHALL have port busy, output, 1, high while in CLASSIFY.

Function
REQ-012 SHALL define six segments with left edges X0 = {50,140,230,335,425,515}.
REQ-013 SHALL place left quadrants (Q0/Q2) at hcnt in [X0+1, X0+37] and right quadrants (Q1/Q3) at [X0+38, X0+74].
REQ-014 SHALL treat vcnt in [151,225] as upper (Q0/Q1) and [226,300] as lower (Q2/Q3).
REQ-015 SHALL, in state ACCUM, add pixel_in[11:8] to the addressed 16-bit quadrant accumulator (24 total) on each pix_valid cycle inside a window; it SHALL be ignored outside all windows.
REQ-016 Each accumulator SHALL saturate at 16'hFFFF with no wrap.
REQ-017 SHALL, when hcnt==0 && vcnt==0 is sampled (frame start, regardless of pix_valid), clear all accumulators on the next edge; in ACCUM the pixel at (0,0) is outside every window.
REQ-018 SHALL, when in ACCUM and hcnt==0 && vcnt==301 is sampled at cycle N, go to CLASSIFY at N+1.
REQ-019 In CLASSIFY, cycle N+1+k (k=0..5) SHALL evaluate segment k: bit q = (acc[k][q] > TH_Qq), strictly greater.
REQ-020 SHALL register seg_pattern and pulse result_valid for exactly cycle N+7, then return to ACCUM.
REQ-021 SHALL hold seg_pattern unchanged between result_valid pulses.
REQ-022 SHALL NOT modify accumulators during CLASSIFY; any windowed pixels then are dropped.
REQ-023 A frame start sampled during CLASSIFY SHALL abort classification: no result_valid, seg_pattern kept, accumulators cleared, back to ACCUM.
REQ-024 A second end trigger while not in ACCUM SHALL be ignored.
REQ-025 States SHALL be exactly ACCUM and CLASSIFY, with a 3-bit segment index 0..5.

Reset
REQ-026 On rst, SHALL clear all accumulators, set seg_pattern=24'h0, result_valid=0, busy=0, state=ACCUM, index=0.
REQ-027 rst mid-CLASSIFY SHALL suppress the pending result_valid.
REQ-028 rst SHALL take priority over frame start and end triggers in the same cycle.

Structure
REQ-029 Package seg_pkg SHALL hold X0 constants, window widths (37/37), row bounds (150/225/300), trigger line 301, default thresholds and the state enum.
REQ-030 Sub-module seg_window_decode (combinational: hcnt,vcnt -> in_win, seg_idx[2:0], quad[1:0]) SHALL be used.

Verification
REQ-031 Full-red frame (pixel_in=12'hF00 every valid cycle): every acc = 2775*15 = 41625 -> seg_pattern=24'hFFFFFF, result_valid exactly 7 cycles after the (0,301) cycle.
REQ-032 Black frame except segment 2 Q1 at 12'hF00: acc=41625 -> seg_pattern=24'h000200; all other nibbles 0.
REQ-033 Edge pixels at red 15 only at hcnt=50,87,88,124,125 and vcnt=150,151,225,226,300,301: accumulation only at 87 (Q0/Q2), 88 and 124 (Q1/Q3) on rows 151,225 (upper) and 226,300 (lower); none at hcnt 50/125 or rows 150/301.
REQ-034 Threshold boundary: acc exactly 20000 -> bit 0; acc 20001 -> bit 1.
REQ-035 Assert rst at N+3 during CLASSIFY -> no result_valid, seg_pattern=0, next frame classifies normally.
REQ-036 Frame start injected at N+2 -> no pulse, prior seg_pattern held, accumulators read 0 at N+3.
